// File: rtl/rs_station_pkg.sv
// Shared constants and opcode encoding for the ALU/branch reservation station.
// Top-level parameters default to these values so the slice stays consistent.
package rs_station_pkg;

   localparam int RS_STATION_SIZE = 8;
   localparam int ROB_ID_WIDTH    = 4;
   localparam int OP_WIDTH        = 6;
   localparam int XLEN_WIDTH      = 32;

   typedef logic [ROB_ID_WIDTH-1:0] rob_id_t;
   typedef logic [XLEN_WIDTH-1:0]   reg_t;
   typedef logic [XLEN_WIDTH-1:0]   imm_t;

   typedef enum logic [OP_WIDTH-1:0] {
      OP_NOP = 6'd0,
      OP_ADD = 6'd1,
      OP_SUB = 6'd2,
      OP_AND = 6'd3,
      OP_OR  = 6'd4,
      OP_XOR = 6'd5,
      OP_BEQ = 6'd6,
      OP_BNE = 6'd7
   } op_e;

endpackage

// File: rtl/first_one_finder.sv
// Priority encoder: reports the lowest set bit of a vector and whether any bit is set.
module first_one_finder
   import rs_station_pkg::*;
#(
   parameter int N     = RS_STATION_SIZE,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     vec,
   output logic [IDX_W-1:0] idx,
   output logic             found
);

   // Scan from the top down so the lowest index is the last (winning) write.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx   = IDX_W'(i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rs_station.sv
// Reservation station for ALU/branch ops: holds entries until operands arrive
// from the rss/lsb result buses, then dispatches the lowest ready entry per cycle.
module rs_station
   import rs_station_pkg::*;
#(
   parameter int RS_SIZE  = RS_STATION_SIZE,
   parameter int ROB_ID_W = ROB_ID_WIDTH,
   parameter int OP_W     = OP_WIDTH,
   parameter int XLEN     = XLEN_WIDTH
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                rdy,
   input  logic                reset_from_rob_bus,
   input  logic [ROB_ID_W-1:0] dest_from_issuer,
   input  logic [OP_W-1:0]     op_from_issuer,
   input  logic [ROB_ID_W-1:0] qj_from_issuer,
   input  logic [ROB_ID_W-1:0] qk_from_issuer,
   input  logic [XLEN-1:0]     vj_from_issuer,
   input  logic [XLEN-1:0]     vk_from_issuer,
   input  logic [XLEN-1:0]     imm_from_issuer,
   input  logic [XLEN-1:0]     pc_from_issuer,
   input  logic [ROB_ID_W-1:0] dest_from_rss_bus,
   input  logic [XLEN-1:0]     value_from_rss_bus,
   input  logic [ROB_ID_W-1:0] dest_from_lsb_bus,
   input  logic [XLEN-1:0]     value_from_lsb_bus,
   output logic                is_full_to_issuer,
   output logic [ROB_ID_W-1:0] dest_to_alu,
   output logic [OP_W-1:0]     op_to_alu,
   output logic [XLEN-1:0]     vj_to_alu,
   output logic [XLEN-1:0]     vk_to_alu,
   output logic [XLEN-1:0]     imm_to_alu,
   output logic [XLEN-1:0]     pc_to_alu
);

   localparam int IDX_W = $clog2(RS_SIZE);
   localparam int CNT_W = IDX_W + 1;

   logic [RS_SIZE-1:0]  busy;
   logic [OP_W-1:0]     op_q   [RS_SIZE];
   logic [ROB_ID_W-1:0] dest_q [RS_SIZE];
   logic [ROB_ID_W-1:0] qj_q   [RS_SIZE];
   logic [ROB_ID_W-1:0] qk_q   [RS_SIZE];
   logic [XLEN-1:0]     vj_q   [RS_SIZE];
   logic [XLEN-1:0]     vk_q   [RS_SIZE];
   logic [XLEN-1:0]     imm_q  [RS_SIZE];
   logic [XLEN-1:0]     pc_q   [RS_SIZE];
   logic [CNT_W-1:0]    busy_count;

   logic [RS_SIZE-1:0] free_vec;
   logic [RS_SIZE-1:0] ready_vec;
   logic [IDX_W-1:0]   free_idx;
   logic [IDX_W-1:0]   ready_idx;
   logic               free_found;
   logic               ready_found;
   logic               insert_req;
   logic               do_insert;

   assign insert_req = (dest_from_issuer != '0);
   assign do_insert  = insert_req && free_found;
   assign free_vec   = ~busy;

   always_comb begin
      ready_vec = '0;
      for (int i = 0; i < RS_SIZE; i++) begin
         ready_vec[i] = busy[i] && (qj_q[i] == '0) && (qk_q[i] == '0);
      end
   end

   first_one_finder #(.N(RS_SIZE), .IDX_W(IDX_W)) u_free_finder (
      .vec   (free_vec),
      .idx   (free_idx),
      .found (free_found)
   );

   first_one_finder #(.N(RS_SIZE), .IDX_W(IDX_W)) u_ready_finder (
      .vec   (ready_vec),
      .idx   (ready_idx),
      .found (ready_found)
   );

   // Dispatch is deliberately left out so the issuer's registered path never overshoots.
   assign is_full_to_issuer =
      ({1'b0, busy_count} + (CNT_W+1)'(insert_req)) >= (CNT_W+1)'(RS_SIZE);

   // Returns {tag, value} after snooping both buses; rss wins when both match.
   function automatic logic [ROB_ID_W+XLEN-1:0] resolve(input logic [ROB_ID_W-1:0] q,
                                                         input logic [XLEN-1:0]     v);
      if (q != '0 && q == dest_from_rss_bus)
         return {{ROB_ID_W{1'b0}}, value_from_rss_bus};
      else if (q != '0 && q == dest_from_lsb_bus)
         return {{ROB_ID_W{1'b0}}, value_from_lsb_bus};
      else
         return {q, v};
   endfunction

   always_ff @(posedge clk) begin
      if (rst || reset_from_rob_bus) begin
         busy        <= '0;
         busy_count  <= '0;
         dest_to_alu <= '0;
         op_to_alu   <= '0;
         vj_to_alu   <= '0;
         vk_to_alu   <= '0;
         imm_to_alu  <= '0;
         pc_to_alu   <= '0;
      end else if (rdy) begin
         for (int i = 0; i < RS_SIZE; i++) begin
            if (busy[i]) begin
               {qj_q[i], vj_q[i]} <= resolve(qj_q[i], vj_q[i]);
               {qk_q[i], vk_q[i]} <= resolve(qk_q[i], vk_q[i]);
            end
         end
         if (ready_found) begin
            dest_to_alu     <= dest_q[ready_idx];
            op_to_alu       <= op_q[ready_idx];
            vj_to_alu       <= vj_q[ready_idx];
            vk_to_alu       <= vk_q[ready_idx];
            imm_to_alu      <= imm_q[ready_idx];
            pc_to_alu       <= pc_q[ready_idx];
            busy[ready_idx] <= 1'b0;
         end else begin
            dest_to_alu <= '0;
         end
         // The free slot was free before this edge, so it never collides with the dispatched one.
         if (do_insert) begin
            busy[free_idx]                       <= 1'b1;
            op_q[free_idx]                       <= op_from_issuer;
            dest_q[free_idx]                     <= dest_from_issuer;
            imm_q[free_idx]                      <= imm_from_issuer;
            pc_q[free_idx]                       <= pc_from_issuer;
            {qj_q[free_idx], vj_q[free_idx]}     <= resolve(qj_from_issuer, vj_from_issuer);
            {qk_q[free_idx], vk_q[free_idx]}     <= resolve(qk_from_issuer, vk_from_issuer);
         end
         busy_count <= busy_count + CNT_W'(do_insert) - CNT_W'(ready_found);
      end
   end

   always @(posedge clk) begin
      if (!rst && !reset_from_rob_bus && rdy && insert_req) begin
         assert (free_found)
            else $error("rs_station: insert into full station, dest=%0d", dest_from_issuer);
      end
   end

endmodule

// File: tb/tb_rs_station.sv
// Directed self-checking bench for rs_station: reset, dispatch latency, wakeup,
// forwarding priority, full flag boundaries, flush and rdy hold.
module tb_rs_station;
   import rs_station_pkg::*;

   localparam int RS_SIZE  = 8;
   localparam int ROB_ID_W = 4;
   localparam int OP_W     = 6;
   localparam int XLEN     = 32;

   logic                clk = 1'b0;
   logic                rst;
   logic                rdy;
   logic                reset_from_rob_bus;
   logic [ROB_ID_W-1:0] dest_from_issuer;
   logic [OP_W-1:0]     op_from_issuer;
   logic [ROB_ID_W-1:0] qj_from_issuer;
   logic [ROB_ID_W-1:0] qk_from_issuer;
   logic [XLEN-1:0]     vj_from_issuer;
   logic [XLEN-1:0]     vk_from_issuer;
   logic [XLEN-1:0]     imm_from_issuer;
   logic [XLEN-1:0]     pc_from_issuer;
   logic [ROB_ID_W-1:0] dest_from_rss_bus;
   logic [XLEN-1:0]     value_from_rss_bus;
   logic [ROB_ID_W-1:0] dest_from_lsb_bus;
   logic [XLEN-1:0]     value_from_lsb_bus;
   logic                is_full_to_issuer;
   logic [ROB_ID_W-1:0] dest_to_alu;
   logic [OP_W-1:0]     op_to_alu;
   logic [XLEN-1:0]     vj_to_alu;
   logic [XLEN-1:0]     vk_to_alu;
   logic [XLEN-1:0]     imm_to_alu;
   logic [XLEN-1:0]     pc_to_alu;

   int checks = 0;
   int errors = 0;

   rs_station #(.RS_SIZE(RS_SIZE), .ROB_ID_W(ROB_ID_W), .OP_W(OP_W), .XLEN(XLEN)) dut (
      .clk                (clk),
      .rst                (rst),
      .rdy                (rdy),
      .reset_from_rob_bus (reset_from_rob_bus),
      .dest_from_issuer   (dest_from_issuer),
      .op_from_issuer     (op_from_issuer),
      .qj_from_issuer     (qj_from_issuer),
      .qk_from_issuer     (qk_from_issuer),
      .vj_from_issuer     (vj_from_issuer),
      .vk_from_issuer     (vk_from_issuer),
      .imm_from_issuer    (imm_from_issuer),
      .pc_from_issuer     (pc_from_issuer),
      .dest_from_rss_bus  (dest_from_rss_bus),
      .value_from_rss_bus (value_from_rss_bus),
      .dest_from_lsb_bus  (dest_from_lsb_bus),
      .value_from_lsb_bus (value_from_lsb_bus),
      .is_full_to_issuer  (is_full_to_issuer),
      .dest_to_alu        (dest_to_alu),
      .op_to_alu          (op_to_alu),
      .vj_to_alu          (vj_to_alu),
      .vk_to_alu          (vk_to_alu),
      .imm_to_alu         (imm_to_alu),
      .pc_to_alu          (pc_to_alu)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      errors++;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_stimulus(input logic [ROB_ID_W-1:0] dest, input logic [OP_W-1:0] op,
                                 input logic [ROB_ID_W-1:0] qj, input logic [ROB_ID_W-1:0] qk,
                                 input logic [XLEN-1:0] vj, input logic [XLEN-1:0] vk,
                                 input logic [XLEN-1:0] imm, input logic [XLEN-1:0] pc);
      dest_from_issuer = dest;
      op_from_issuer   = op;
      qj_from_issuer   = qj;
      qk_from_issuer   = qk;
      vj_from_issuer   = vj;
      vk_from_issuer   = vk;
      imm_from_issuer  = imm;
      pc_from_issuer   = pc;
   endtask

   task automatic clear_issuer();
      apply_stimulus('0, '0, '0, '0, '0, '0, '0, '0);
   endtask

   task automatic drive_buses(input logic [ROB_ID_W-1:0] rtag, input logic [XLEN-1:0] rval,
                              input logic [ROB_ID_W-1:0] ltag, input logic [XLEN-1:0] lval);
      dest_from_rss_bus  = rtag;
      value_from_rss_bus = rval;
      dest_from_lsb_bus  = ltag;
      value_from_lsb_bus = lval;
   endtask

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      checks++;
      assert (observed === expected)
         else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
         end
   endtask

   initial begin
      rst                = 1'b1;
      rdy                = 1'b1;
      reset_from_rob_bus = 1'b0;
      clear_issuer();
      drive_buses('0, '0, '0, '0);

      // Reset held for two cycles
      tick();
      tick();
      check_output("reset_dest", 32'(dest_to_alu), 32'h0);
      check_output("reset_full", 32'(is_full_to_issuer), 32'h0);
      check_output("reset_count", 32'(dut.busy_count), 32'h0);
      check_output("reset_vj", vj_to_alu, 32'h0);
      rst = 1'b0;

      // Ready insert dispatches two edges later
      $display("[TB] ready insert");
      apply_stimulus(4'd3, OP_ADD, 4'd0, 4'd0, 32'd5, 32'd7, 32'h20, 32'h100);
      tick();
      clear_issuer();
      check_output("ready_not_yet", 32'(dest_to_alu), 32'h0);
      check_output("ready_count", 32'(dut.busy_count), 32'h1);
      tick();
      check_output("ready_dest", 32'(dest_to_alu), 32'h3);
      check_output("ready_op", 32'(op_to_alu), 32'(OP_ADD));
      check_output("ready_vj", vj_to_alu, 32'd5);
      check_output("ready_vk", vk_to_alu, 32'd7);
      check_output("ready_imm", imm_to_alu, 32'h20);
      check_output("ready_pc", pc_to_alu, 32'h100);
      tick();
      check_output("ready_idle", 32'(dest_to_alu), 32'h0);
      check_output("ready_drained", 32'(dut.busy_count), 32'h0);

      // Wakeup from rss bus after idle cycles
      $display("[TB] rss wakeup");
      apply_stimulus(4'd4, OP_SUB, 4'd2, 4'd0, 32'd0, 32'd1, 32'h4, 32'h104);
      tick();
      clear_issuer();
      for (int i = 0; i < 3; i++) begin
         tick();
         check_output("wake_blocked", 32'(dest_to_alu), 32'h0);
      end
      drive_buses(4'd2, 32'h10, 4'd0, 32'h0);
      tick();
      drive_buses('0, '0, '0, '0);
      check_output("wake_edge", 32'(dest_to_alu), 32'h0);
      tick();
      check_output("wake_dest", 32'(dest_to_alu), 32'h4);
      check_output("wake_vj", vj_to_alu, 32'h10);
      check_output("wake_vk", vk_to_alu, 32'h1);
      tick();

      // Insert-time forwarding with both buses on the same tag
      $display("[TB] insert forwarding");
      apply_stimulus(4'd5, OP_AND, 4'd6, 4'd0, 32'hdead, 32'd3, 32'h8, 32'h108);
      drive_buses(4'd6, 32'hA, 4'd6, 32'hB);
      tick();
      clear_issuer();
      drive_buses('0, '0, '0, '0);
      tick();
      check_output("fwd_dest", 32'(dest_to_alu), 32'h5);
      check_output("fwd_vj", vj_to_alu, 32'hA);
      tick();

      // Wakeup priority: rss beats lsb on qk
      $display("[TB] wakeup priority");
      apply_stimulus(4'd3, OP_OR, 4'd0, 4'd4, 32'd1, 32'd0, 32'h0, 32'h10c);
      tick();
      clear_issuer();
      drive_buses(4'd4, 32'h44, 4'd4, 32'h55);
      tick();
      drive_buses('0, '0, '0, '0);
      tick();
      check_output("prio_dest", 32'(dest_to_alu), 32'h3);
      check_output("prio_vk", vk_to_alu, 32'h44);
      tick();

      // Fill the station with blocked entries
      $display("[TB] full");
      for (int i = 1; i <= 7; i++) begin
         apply_stimulus(4'(i), OP_XOR, 4'd9, 4'd0, 32'd0, 32'(i), 32'(i), 32'h200);
         if (i == 7) check_output("full_at_7th", 32'(is_full_to_issuer), 32'h0);
         tick();
      end
      check_output("full_count7", 32'(dut.busy_count), 32'h7);
      apply_stimulus(4'd8, OP_XOR, 4'd9, 4'd0, 32'd0, 32'd8, 32'd8, 32'h200);
      check_output("full_8th_presented", 32'(is_full_to_issuer), 32'h1);
      tick();
      clear_issuer();
      check_output("full_held", 32'(is_full_to_issuer), 32'h1);
      check_output("full_count8", 32'(dut.busy_count), 32'h8);
      drive_buses('0, '0, 4'd9, 32'h99);
      tick();
      drive_buses('0, '0, '0, '0);
      check_output("full_wake_edge", 32'(dest_to_alu), 32'h0);
      for (int i = 1; i <= 8; i++) begin
         tick();
         check_output("drain_dest", 32'(dest_to_alu), 32'(i));
         check_output("drain_vj", vj_to_alu, 32'h99);
         if (i == 1) check_output("full_released", 32'(is_full_to_issuer), 32'h0);
      end
      tick();
      check_output("drain_count", 32'(dut.busy_count), 32'h0);

      // rdy low: insert ignored
      $display("[TB] rdy hold");
      rdy = 1'b0;
      apply_stimulus(4'd6, OP_ADD, 4'd0, 4'd0, 32'd1, 32'd1, 32'd0, 32'h300);
      tick();
      check_output("rdy_count", 32'(dut.busy_count), 32'h0);
      clear_issuer();
      rdy = 1'b1;
      tick();
      check_output("rdy_no_dispatch", 32'(dest_to_alu), 32'h0);

      // Flush with five busy entries and a ready insert presented
      $display("[TB] flush");
      for (int i = 10; i <= 14; i++) begin
         apply_stimulus(4'(i), OP_BEQ, 4'd15, 4'd0, 32'd0, 32'd0, 32'd0, 32'h400);
         tick();
      end
      check_output("flush_pre_count", 32'(dut.busy_count), 32'h5);
      apply_stimulus(4'd2, OP_BNE, 4'd0, 4'd0, 32'd1, 32'd2, 32'd0, 32'h500);
      reset_from_rob_bus = 1'b1;
      tick();
      reset_from_rob_bus = 1'b0;
      clear_issuer();
      check_output("flush_count", 32'(dut.busy_count), 32'h0);
      check_output("flush_dest", 32'(dest_to_alu), 32'h0);
      check_output("flush_full", 32'(is_full_to_issuer), 32'h0);
      drive_buses(4'd15, 32'h77, 4'd0, 32'h0);
      tick();
      drive_buses('0, '0, '0, '0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_output("flush_quiet", 32'(dest_to_alu), 32'h0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
